// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: instruction-fetch stage with an in-order response queue.
// Owns the fetch PC, issues one request per cycle while queue credit allows,
// buffers returned words with their PCs, and drives the IF/ID register.
// Optional build macro: FETCH_PERF_EN adds PerfFetched / PerfBubbles counters.

module fetch_queue_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemRvalid,
    input  logic [31:0] ImemRdata,
`ifdef FETCH_PERF_EN
    output logic [31:0] PerfFetched,
    output logic [31:0] PerfBubbles,
`endif
    output logic        ValidD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D
);

    localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Fetch PC and outstanding-request tracking
    logic [31:0]      pcf_q, pcf_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;

    // Response queue
    logic [31:0]      q_data_q [DEPTH];
    logic [31:0]      q_pc_q   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // IF/ID register
    logic             valid_q, valid_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pcd_q, pcd_d;
    logic [31:0]      pcp4_q, pcp4_d;

    // Control
    logic [CNT_W:0]   occ_s;
    logic             issue_s;
    logic             rsp_ok_s;
    logic             q_empty_s;
    logic             push_s;
    logic             pop_s;

    // The inflight flag acts as the epoch tag: a redirect or reset clears it,
    // so any response belonging to a squashed request is never accepted.
    assign rsp_ok_s  = ImemRvalid & inflight_q;
    assign q_empty_s = (count_q == {CNT_W{1'b0}});

    // Issue decision: occupancy plus outstanding request must leave room
    always_comb begin
        occ_s   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        issue_s = 1'b0;
        if (rst) begin
            issue_s = 1'b0;
        end else if (PCSrcE) begin
            issue_s = 1'b0;
        end else if (occ_s < (CNT_W + 1)'(DEPTH)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Next-state for PC, queue control and IF/ID register
    always_comb begin
        pcf_d         = pcf_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        push_s        = 1'b0;
        pop_s         = 1'b0;
        valid_d       = valid_q;
        instr_d       = instr_q;
        pcd_d         = pcd_q;
        pcp4_d        = pcp4_q;

        if (rst) begin
            // Registers take their reset values in the sequential blocks.
            inflight_d = 1'b0;
        end else if (PCSrcE) begin
            // Redirect: new PC, drop queued and in-flight work, inject a bubble.
            pcf_d      = PCTargetE;
            inflight_d = 1'b0;
            wr_ptr_d   = {PTR_W{1'b0}};
            rd_ptr_d   = {PTR_W{1'b0}};
            count_d    = {CNT_W{1'b0}};
            valid_d    = 1'b0;
            instr_d    = NOP_INSN;
        end else begin
            if (issue_s) begin
                pcf_d         = pcf_q + 32'd4;
                inflight_d    = 1'b1;
                inflight_pc_d = pcf_q;
            end else begin
                inflight_d    = 1'b0;
            end

            if (StallD) begin
                // IF/ID holds; a returning word still lands in the queue.
                push_s = rsp_ok_s;
            end else if (!q_empty_s) begin
                pop_s   = 1'b1;
                push_s  = rsp_ok_s;
                valid_d = 1'b1;
                instr_d = q_data_q[rd_ptr_q];
                pcd_d   = q_pc_q[rd_ptr_q];
                pcp4_d  = q_pc_q[rd_ptr_q] + 32'd4;
            end else if (rsp_ok_s) begin
                // Empty queue: forward the arriving word directly.
                valid_d = 1'b1;
                instr_d = ImemRdata;
                pcd_d   = inflight_pc_q;
                pcp4_d  = inflight_pc_q + 32'd4;
            end else begin
                valid_d = 1'b0;
                instr_d = NOP_INSN;
            end

            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1'b1);
                2'b01:   count_d = count_q - CNT_W'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // Fetch PC, in-flight tracking and queue pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            pcf_q         <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
            wr_ptr_q      <= {PTR_W{1'b0}};
            rd_ptr_q      <= {PTR_W{1'b0}};
            count_q       <= {CNT_W{1'b0}};
        end else begin
            pcf_q         <= pcf_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage: write {data, PC} at the tail on push
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_data_q[i] <= 32'h0000_0000;
                q_pc_q[i]   <= 32'h0000_0000;
            end
        end else if (push_s) begin
            q_data_q[wr_ptr_q] <= ImemRdata;
            q_pc_q[wr_ptr_q]   <= inflight_pc_q;
        end else begin
            q_data_q[wr_ptr_q] <= q_data_q[wr_ptr_q];
            q_pc_q[wr_ptr_q]   <= q_pc_q[wr_ptr_q];
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSN;
            pcd_q   <= 32'h0000_0000;
            pcp4_q  <= 32'h0000_0004;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4_q  <= pcp4_d;
        end
    end

    assign ImemReq  = issue_s;
    assign ImemAddr = pcf_q;
    assign ValidD   = valid_q;
    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_bubbles_q;
    logic        bubble_load_s;

    // A bubble is loaded on redirect, or when unstalled with nothing to deliver.
    assign bubble_load_s = ~rst & (PCSrcE | (~StallD & q_empty_s & ~rsp_ok_s));

    // Performance counters, free-running modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= 32'h0000_0000;
            perf_bubbles_q <= 32'h0000_0000;
        end else begin
            if (issue_s) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end else begin
                perf_fetched_q <= perf_fetched_q;
            end
            if (bubble_load_s) begin
                perf_bubbles_q <= perf_bubbles_q + 32'd1;
            end else begin
                perf_bubbles_q <= perf_bubbles_q;
            end
        end
    end

    assign PerfFetched = perf_fetched_q;
    assign PerfBubbles = perf_bubbles_q;
`endif

endmodule
